lsu_ctrl: RTL and testbench

Parametrised, sequential load/store controller between the core's execute stage and the data memory port. It accepts one load or store per handshake and derives byte-lane position from the low address bits. It drives a valid/ready memory request with a per-byte write mask and sign- or zero-extends returned load data. Misaligned accesses are either split into two memory beats or rejected with an error, selected by parameter.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_lane_align.sv | 59 +++++
 rtl/lsu_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store controller.
package lsu_pkg;

    // Access size encoding as presented by the execute stage
    typedef enum logic [2:0] {
        SZ_B   = 3'b000,
        SZ_H   = 3'b001,
        SZ_W   = 3'b010,
        SZ_D   = 3'b011,
        SZ_BU  = 3'b100,
        SZ_HU  = 3'b101,
        SZ_WU  = 3'b110,
        SZ_BAD = 3'b111
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_RSP0,
        ST_REQ1,
        ST_RSP1,
        ST_DONE
    } lsu_state_e;

    // Number of bytes touched by an access; the illegal code reports 8 and is
    // rejected elsewhere before it matters.
    function automatic logic [3:0] nbytes(input lsu_size_e size);
        case (size)
            SZ_B, SZ_BU: nbytes = 4'd1;
            SZ_H, SZ_HU: nbytes = 4'd2;
            SZ_W, SZ_WU: nbytes = 4'd4;
            default:     nbytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: builds the two-beat store window and extracts and
// extends load data from the two-beat read buffer.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  lsu_size_e                       i_size,
    input  logic [$clog2(DATA_W/8)-1:0]     i_off,
    input  logic [DATA_W-1:0]               i_wdata,
    input  logic [2*DATA_W-1:0]             i_rbuf,
    output logic [2*DATA_W-1:0]             o_win_data,
    output logic [2*(DATA_W/8)-1:0]         o_win_mask,
    output logic [DATA_W-1:0]               o_ldata
);

    localparam int NB = DATA_W / 8;
    localparam int MW = 2 * NB;

    logic [MW-1:0]         w_mbase;
    logic [DATA_W-1:0]     w_sh;
    logic signed [7:0]     w_sb;
    logic signed [15:0]    w_sh16;
    logic signed [31:0]    w_sw32;

    assign o_win_data = {{DATA_W{1'b0}}, i_wdata} << {i_off, 3'b000};
    assign o_win_mask = w_mbase << i_off;

    // Only the low DATA_W bits of the shifted buffer can hold the access
    assign w_sh   = DATA_W'(i_rbuf >> {i_off, 3'b000});
    assign w_sb   = w_sh[7:0];
    assign w_sh16 = w_sh[15:0];
    assign w_sw32 = w_sh[31:0];

    // Contiguous byte-enable run sized by the access, before lane shifting
    always_comb begin
        case (nbytes(i_size))
            4'd1:    w_mbase = MW'(8'h01);
            4'd2:    w_mbase = MW'(8'h03);
            4'd4:    w_mbase = MW'(8'h0F);
            default: w_mbase = MW'(8'hFF);
        endcase
    end

    // Truncate to the access size, then sign- or zero-extend
    always_comb begin
        case (i_size)
            SZ_B:    o_ldata = DATA_W'(w_sb);
            SZ_BU:   o_ldata = DATA_W'(w_sh[7:0]);
            SZ_H:    o_ldata = DATA_W'(w_sh16);
            SZ_HU:   o_ldata = DATA_W'(w_sh[15:0]);
            SZ_W:    o_ldata = DATA_W'(w_sw32);
            SZ_WU:   o_ldata = DATA_W'(w_sh[31:0]);
            SZ_D:    o_ldata = w_sh;
            default: o_ldata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one core request, issues one or two memory
// beats, and returns an extended load result or an error pulse.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_size,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e           r_state;
    logic                 r_we;
    lsu_size_e            r_size;
    logic [OFF_W-1:0]     r_off;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_mis;
    logic [DATA_W-1:0]    r_rbuf_lo;
    logic                 r_req_ready;
    logic                 r_mem_req_valid;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic                 r_mem_we;
    logic [DATA_W-1:0]    r_mem_wdata;
    logic [NB-1:0]        r_mem_wmask;
    logic                 r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_rdata;
    logic                 r_rsp_err;

    lsu_size_e            w_size_in;
    logic [OFF_W-1:0]     w_off_in;
    logic [4:0]           w_end_in;
    logic                 w_mis_in;
    logic                 w_illegal_in;
    logic [ADDR_W-1:0]    w_addr_al_in;
    lsu_size_e            w_al_size;
    logic [OFF_W-1:0]     w_al_off;
    logic [DATA_W-1:0]    w_al_wdata;
    logic [2*DATA_W-1:0]  w_al_rbuf;
    logic [2*DATA_W-1:0]  w_win_data;
    logic [2*NB-1:0]      w_win_mask;
    logic [DATA_W-1:0]    w_ldata;

    assign w_size_in    = lsu_size_e'(req_size);
    assign w_off_in     = req_addr[OFF_W-1:0];
    assign w_end_in     = 5'(w_off_in) + {1'b0, nbytes(w_size_in)};
    assign w_mis_in     = (w_end_in > 5'(NB));
    assign w_addr_al_in = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_illegal_in = (w_size_in == SZ_BAD)
                        || ((DATA_W == 32) && ((w_size_in == SZ_D) || (w_size_in == SZ_WU)))
                        || (w_mis_in && (MISALIGN_SPLIT == 0));

    // In IDLE the aligner sees the incoming request so beat 0 can be
    // registered on acceptance; afterwards it sees the captured request.
    // The read buffer is presented with this cycle's mem_rdata merged in so
    // the load result can be registered on the completing response.
    assign w_al_size  = (r_state == ST_IDLE) ? w_size_in : r_size;
    assign w_al_off   = (r_state == ST_IDLE) ? w_off_in  : r_off;
    assign w_al_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
    assign w_al_rbuf  = (r_state == ST_RSP1) ? {mem_rdata, r_rbuf_lo}
                                             : {{DATA_W{1'b0}}, mem_rdata};

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .i_size     (w_al_size),
        .i_off      (w_al_off),
        .i_wdata    (w_al_wdata),
        .i_rbuf     (w_al_rbuf),
        .o_win_data (w_win_data),
        .o_win_mask (w_win_mask),
        .o_ldata    (w_ldata)
    );

    assign req_ready     = r_req_ready;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_we        = r_mem_we;
    assign mem_wdata     = r_mem_wdata;
    assign mem_wmask     = r_mem_wmask;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_err       = r_rsp_err;

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_we            <= 1'b0;
            r_size          <= SZ_B;
            r_off           <= '0;
            r_wdata         <= '0;
            r_mis           <= 1'b0;
            r_rbuf_lo       <= '0;
            r_req_ready     <= 1'b1;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_we        <= 1'b0;
            r_mem_wdata     <= '0;
            r_mem_wmask     <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_rdata     <= '0;
            r_rsp_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_we        <= req_we;
                        r_size      <= w_size_in;
                        r_off       <= w_off_in;
                        r_wdata     <= req_wdata;
                        r_mis       <= w_mis_in;
                        if (w_illegal_in) begin
                            r_state     <= ST_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state         <= ST_REQ0;
                            r_mem_req_valid <= 1'b1;
                            r_mem_addr      <= w_addr_al_in;
                            r_mem_we        <= req_we;
                            r_mem_wdata     <= w_win_data[DATA_W-1:0];
                            r_mem_wmask     <= w_win_mask[NB-1:0];
                        end
                    end
                end
                ST_REQ0: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= ST_RSP0;
                    end
                end
                ST_RSP0: begin
                    if (mem_rsp_valid) begin
                        r_rbuf_lo <= mem_rdata;
                        if (r_mis) begin
                            r_state         <= ST_REQ1;
                            r_mem_req_valid <= 1'b1;
                            r_mem_addr      <= r_mem_addr + ADDR_W'(NB);
                            r_mem_wdata     <= w_win_data[2*DATA_W-1:DATA_W];
                            r_mem_wmask     <= w_win_mask[2*NB-1:NB];
                        end else begin
                            r_state     <= ST_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= r_we ? '0 : w_ldata;
                        end
                    end
                end
                ST_REQ1: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= ST_RSP1;
                    end
                end
                ST_RSP1: begin
                    if (mem_rsp_valid) begin
                        r_state     <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_we ? '0 : w_ldata;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: three instances (32-bit split, 32-bit
// reject, 64-bit split) share the stimulus; one is selected at a time.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          sel = 0;
    int          total = 0;
    int          bad = 0;

    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_size = 3'b000;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rdata = '0;

    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_mem_req_valid, a_mem_we;
    logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_wmask;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_mem_req_valid, b_mem_we;
    logic [31:0] b_rsp_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_wmask;
    logic        c_req_ready, c_rsp_valid, c_rsp_err, c_mem_req_valid, c_mem_we;
    logic [63:0] c_rsp_rdata, c_mem_wdata;
    logic [31:0] c_mem_addr;
    logic [7:0]  c_mem_wmask;

    logic        s_req_ready, s_rsp_valid, s_rsp_err, s_mem_req_valid, s_mem_we;
    logic [63:0] s_rsp_rdata, s_mem_wdata;
    logic [31:0] s_mem_addr;
    logic [7:0]  s_mem_wmask;

    always #5 clk = ~clk;

    lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid && (sel == 0)), .req_ready(a_req_ready),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(a_mem_addr),
        .mem_we(a_mem_we), .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata[31:0]));

    lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid && (sel == 1)), .req_ready(b_req_ready),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(b_mem_addr),
        .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata[31:0]));

    lsu_ctrl #(.DATA_W(64), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_c (
        .clk(clk), .rst(rst), .req_valid(req_valid && (sel == 2)), .req_ready(c_req_ready),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(c_rsp_valid), .rsp_rdata(c_rsp_rdata), .rsp_err(c_rsp_err),
        .mem_req_valid(c_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(c_mem_addr),
        .mem_we(c_mem_we), .mem_wdata(c_mem_wdata), .mem_wmask(c_mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata));

    always_comb begin
        s_req_ready = a_req_ready;  s_rsp_valid = a_rsp_valid;  s_rsp_err = a_rsp_err;
        s_rsp_rdata = {32'h0, a_rsp_rdata};  s_mem_req_valid = a_mem_req_valid;
        s_mem_addr = a_mem_addr;  s_mem_we = a_mem_we;  s_mem_wdata = {32'h0, a_mem_wdata};
        s_mem_wmask = {4'h0, a_mem_wmask};
        if (sel == 1) begin
            s_req_ready = b_req_ready;  s_rsp_valid = b_rsp_valid;  s_rsp_err = b_rsp_err;
            s_rsp_rdata = {32'h0, b_rsp_rdata};  s_mem_req_valid = b_mem_req_valid;
            s_mem_addr = b_mem_addr;  s_mem_we = b_mem_we;  s_mem_wdata = {32'h0, b_mem_wdata};
            s_mem_wmask = {4'h0, b_mem_wmask};
        end else if (sel == 2) begin
            s_req_ready = c_req_ready;  s_rsp_valid = c_rsp_valid;  s_rsp_err = c_rsp_err;
            s_rsp_rdata = c_rsp_rdata;  s_mem_req_valid = c_mem_req_valid;
            s_mem_addr = c_mem_addr;  s_mem_we = c_mem_we;  s_mem_wdata = c_mem_wdata;
            s_mem_wmask = c_mem_wmask;
        end
    end

    // Results of the last transaction driven by run()
    int          r_cyc, r_nbeats, r_seen, r_unstable;
    logic [63:0] r_rdata;
    logic        r_err;
    logic [31:0] r_baddr [2];
    logic [63:0] r_bdata [2];
    logic [7:0]  r_bmask [2];
    logic        r_bwe   [2];

    // Issues one request and plays a memory that answers each beat one cycle
    // after its handshake, holding mem_req_ready low for 'stall' cycles.
    // Cycle numbers count edges after the accepting edge.
    task automatic run(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [63:0] wdata, input logic [63:0] rd0, input logic [63:0] rd1,
                       input int stall);
        int          waitcnt;
        int          guard;
        logic        pend;
        logic        have_snap;
        logic [31:0] sn_addr;
        logic [63:0] sn_data;
        logic [7:0]  sn_mask;
        logic        sn_we;
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
        guard = 0;
        while (!s_req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        r_cyc = -1; r_nbeats = 0; r_seen = 0; r_unstable = 0; r_rdata = '0; r_err = 1'b0;
        pend = 1'b0; waitcnt = 0; have_snap = 1'b0;
        sn_addr = '0; sn_data = '0; sn_mask = '0; sn_we = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (s_rsp_valid) begin
                r_cyc = c; r_rdata = s_rsp_rdata; r_err = s_rsp_err;
                break;
            end
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (s_mem_req_valid) begin
                r_seen++;
                if (!have_snap) begin
                    sn_addr = s_mem_addr; sn_data = s_mem_wdata; sn_mask = s_mem_wmask; sn_we = s_mem_we;
                    have_snap = 1'b1;
                end else if (sn_addr !== s_mem_addr || sn_data !== s_mem_wdata ||
                             sn_mask !== s_mem_wmask || sn_we !== s_mem_we) begin
                    r_unstable++;
                end
            end
            if (pend) begin
                mem_rsp_valid = 1'b1;
                mem_rdata = (r_nbeats == 1) ? rd0 : rd1;
                pend = 1'b0;
            end else if (s_mem_req_valid) begin
                if (waitcnt < stall) begin
                    waitcnt++;
                end else begin
                    if (r_nbeats < 2) begin
                        r_baddr[r_nbeats] = s_mem_addr; r_bdata[r_nbeats] = s_mem_wdata;
                        r_bmask[r_nbeats] = s_mem_wmask; r_bwe[r_nbeats] = s_mem_we;
                    end
                    r_nbeats++;
                    mem_req_ready = 1'b1;
                    pend = 1'b1;
                    waitcnt = 0;
                    have_snap = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (s_req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got %b exp 1", s_req_ready); end
        total++; if (s_mem_req_valid !== 1'b0 || s_mem_we !== 1'b0 || s_mem_addr !== 32'h0 ||
                     s_mem_wdata !== 64'h0 || s_mem_wmask !== 8'h0) begin
            bad++; $display("FAIL rst_mem_outs got v=%b we=%b a=%h d=%h m=%h exp all 0",
                            s_mem_req_valid, s_mem_we, s_mem_addr, s_mem_wdata, s_mem_wmask);
        end
        total++; if (s_rsp_valid !== 1'b0 || s_rsp_rdata !== 64'h0 || s_rsp_err !== 1'b0) begin
            bad++; $display("FAIL rst_rsp_outs got v=%b d=%h e=%b exp all 0", s_rsp_valid, s_rsp_rdata, s_rsp_err);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        // Start a store and abort it while REQ0 waits for mem_req_ready
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'b000; req_addr = 32'h1003; req_wdata = 64'hA5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++; if (s_mem_req_valid !== 1'b1) begin bad++; $display("FAIL mid_req0_valid got %b exp 1", s_mem_req_valid); end
        #2 rst = 1'b0;
        #1;
        total++; if (s_req_ready !== 1'b1 || s_mem_req_valid !== 1'b0 || s_mem_we !== 1'b0 ||
                     s_mem_addr !== 32'h0 || s_mem_wdata !== 64'h0 || s_mem_wmask !== 8'h0) begin
            bad++; $display("FAIL async_rst_outs got rdy=%b v=%b we=%b a=%h d=%h m=%h exp 1,0,0,0,0,0",
                            s_req_ready, s_mem_req_valid, s_mem_we, s_mem_addr, s_mem_wdata, s_mem_wmask);
        end
        total++; if (s_rsp_valid !== 1'b0 || s_rsp_rdata !== 64'h0 || s_rsp_err !== 1'b0) begin
            bad++; $display("FAIL async_rst_rsp got v=%b d=%h e=%b exp 0", s_rsp_valid, s_rsp_rdata, s_rsp_err);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        mem_rsp_valid = 1'b1; mem_rdata = 64'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (s_rsp_valid !== 1'b0) begin bad++; $display("FAIL stray_rsp_%0d got %b exp 0", i, s_rsp_valid); end
        end
        mem_rsp_valid = 1'b0;
        total++; if (s_req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got %b exp 1", s_req_ready); end
    endtask

    task automatic test_byte_store();
        sel = 0;
        run(1'b1, 3'b000, 32'h1003, 64'hA5, 64'h0, 64'h0, 0);
        total++; if (r_cyc !== 3) begin bad++; $display("FAIL sb_latency got %0d exp 3", r_cyc); end
        total++; if (r_nbeats !== 1) begin bad++; $display("FAIL sb_beats got %0d exp 1", r_nbeats); end
        total++; if (r_baddr[0] !== 32'h1000 || r_bmask[0] !== 8'b1000 || r_bdata[0] !== 64'hA500_0000 || r_bwe[0] !== 1'b1) begin
            bad++; $display("FAIL sb_beat got a=%h m=%b d=%h we=%b exp 1000,00001000,a5000000,1",
                            r_baddr[0], r_bmask[0], r_bdata[0], r_bwe[0]);
        end
        total++; if (r_rdata !== 64'h0 || r_err !== 1'b0) begin bad++; $display("FAIL sb_rsp got d=%h e=%b exp 0,0", r_rdata, r_err); end
    endtask

    task automatic test_half_loads();
        sel = 0;
        run(1'b0, 3'b001, 32'h2002, 64'h0, 64'h8001_0000, 64'h0, 0);
        total++; if (r_rdata !== 64'hFFFF_8001) begin bad++; $display("FAIL lh_data got %h exp ffff8001", r_rdata); end
        total++; if (r_baddr[0] !== 32'h2000 || r_bmask[0] !== 8'b1100 || r_bwe[0] !== 1'b0 || r_cyc !== 3) begin
            bad++; $display("FAIL lh_beat got a=%h m=%b we=%b cyc=%0d exp 2000,00001100,0,3", r_baddr[0], r_bmask[0], r_bwe[0], r_cyc);
        end
        run(1'b0, 3'b101, 32'h2002, 64'h0, 64'h8001_0000, 64'h0, 0);
        total++; if (r_rdata !== 64'h0000_8001) begin bad++; $display("FAIL lhu_data got %h exp 00008001", r_rdata); end
    endtask

    task automatic test_split();
        sel = 0;
        run(1'b0, 3'b010, 32'h0000_0003, 64'h0, 64'h4433_2211, 64'h8877_6655, 0);
        total++; if (r_rdata !== 64'h7766_5544) begin bad++; $display("FAIL split_lw_data got %h exp 77665544", r_rdata); end
        total++; if (r_cyc !== 5 || r_nbeats !== 2) begin bad++; $display("FAIL split_lw_timing got cyc=%0d beats=%0d exp 5,2", r_cyc, r_nbeats); end
        total++; if (r_baddr[0] !== 32'h0 || r_baddr[1] !== 32'h4) begin bad++; $display("FAIL split_lw_addr got %h,%h exp 0,4", r_baddr[0], r_baddr[1]); end
        // Store crossing the top of the address space wraps to address 0
        run(1'b1, 3'b010, 32'hFFFF_FFFF, 64'hDDCC_BBAA, 64'h0, 64'h0, 0);
        total++; if (r_baddr[0] !== 32'hFFFF_FFFC || r_baddr[1] !== 32'h0) begin
            bad++; $display("FAIL wrap_addr got %h,%h exp fffffffc,00000000", r_baddr[0], r_baddr[1]);
        end
        total++; if (r_bdata[0] !== 64'hAA00_0000 || r_bdata[1] !== 64'h00DD_CCBB) begin
            bad++; $display("FAIL split_sw_data got %h,%h exp aa000000,00ddccbb", r_bdata[0], r_bdata[1]);
        end
        total++; if (r_bmask[0] !== 8'b1000 || r_bmask[1] !== 8'b0111) begin
            bad++; $display("FAIL split_sw_mask got %b,%b exp 00001000,00000111", r_bmask[0], r_bmask[1]);
        end
    endtask

    task automatic test_errors();
        sel = 1;
        run(1'b1, 3'b010, 32'h0000_0002, 64'h1111_2222, 64'h0, 64'h0, 0);
        total++; if (r_err !== 1'b1 || r_cyc !== 1) begin bad++; $display("FAIL misalign_err got e=%b cyc=%0d exp 1,1", r_err, r_cyc); end
        total++; if (r_seen !== 0 || r_rdata !== 64'h0) begin bad++; $display("FAIL misalign_nomem got seen=%0d d=%h exp 0,0", r_seen, r_rdata); end
        run(1'b0, 3'b000, 32'h0000_0007, 64'h0, 64'h8012_3456, 64'h0, 0);
        total++; if (r_rdata !== 64'hFFFF_FF80 || r_err !== 1'b0 || r_cyc !== 3) begin
            bad++; $display("FAIL lb_nosplit got d=%h e=%b cyc=%0d exp ffffff80,0,3", r_rdata, r_err, r_cyc);
        end
        sel = 0;
        run(1'b0, 3'b011, 32'h0000_0000, 64'h0, 64'h0, 64'h0, 0);
        total++; if (r_err !== 1'b1 || r_cyc !== 1 || r_seen !== 0) begin bad++; $display("FAIL ld32_err got e=%b cyc=%0d seen=%0d exp 1,1,0", r_err, r_cyc, r_seen); end
        run(1'b0, 3'b111, 32'h0000_0000, 64'h0, 64'h0, 64'h0, 0);
        total++; if (r_err !== 1'b1 || r_cyc !== 1) begin bad++; $display("FAIL size111_err got e=%b cyc=%0d exp 1,1", r_err, r_cyc); end
        run(1'b0, 3'b110, 32'h0000_0000, 64'h0, 64'h0, 64'h0, 0);
        total++; if (r_err !== 1'b1) begin bad++; $display("FAIL lwu32_err got %b exp 1", r_err); end
    endtask

    task automatic test_dword_wait();
        sel = 2;
        run(1'b0, 3'b011, 32'h0000_0010, 64'h0, 64'h8877_6655_4433_2211, 64'h0, 3);
        total++; if (r_cyc !== 6) begin bad++; $display("FAIL ld_wait_latency got %0d exp 6", r_cyc); end
        total++; if (r_unstable !== 0 || r_seen !== 4) begin bad++; $display("FAIL ld_wait_stable got unstable=%0d seen=%0d exp 0,4", r_unstable, r_seen); end
        total++; if (r_rdata !== 64'h8877_6655_4433_2211 || r_baddr[0] !== 32'h10 || r_bmask[0] !== 8'hFF) begin
            bad++; $display("FAIL ld_data got d=%h a=%h m=%h exp 8877665544332211,10,ff", r_rdata, r_baddr[0], r_bmask[0]);
        end
        run(1'b0, 3'b010, 32'h0000_0014, 64'h0, 64'h89AB_CDEF_0000_0000, 64'h0, 0);
        total++; if (r_rdata !== 64'hFFFF_FFFF_89AB_CDEF) begin bad++; $display("FAIL lw64_data got %h exp ffffffff89abcdef", r_rdata); end
        run(1'b0, 3'b110, 32'h0000_0014, 64'h0, 64'h89AB_CDEF_0000_0000, 64'h0, 0);
        total++; if (r_rdata !== 64'h0000_0000_89AB_CDEF || r_err !== 1'b0) begin bad++; $display("FAIL lwu64_data got %h e=%b exp 0000000089abcdef,0", r_rdata, r_err); end
        run(1'b0, 3'b011, 32'h0000_0004, 64'h0, 64'h4433_2211_AAAA_AAAA, 64'hBBBB_BBBB_8877_6655, 0);
        total++; if (r_rdata !== 64'h8877_6655_4433_2211 || r_cyc !== 5 || r_baddr[1] !== 32'h8) begin
            bad++; $display("FAIL split_ld64 got d=%h cyc=%0d a1=%h exp 8877665544332211,5,8", r_rdata, r_cyc, r_baddr[1]);
        end
    endtask

    task automatic test_back_to_back();
        sel = 0;
        run(1'b0, 3'b100, 32'h0000_0001, 64'h0, 64'h0000_5A00, 64'h0, 0);
        total++; if (r_rdata !== 64'h5A) begin bad++; $display("FAIL lbu_data got %h exp 5a", r_rdata); end
        @(posedge clk); #1;
        total++; if (s_req_ready !== 1'b1 || s_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL ready_after_rsp got rdy=%b v=%b exp 1,0", s_req_ready, s_rsp_valid);
        end
        run(1'b1, 3'b001, 32'h0000_0002, 64'hBEEF, 64'h0, 64'h0, 0);
        total++; if (r_bdata[0] !== 64'hBEEF_0000 || r_bmask[0] !== 8'b1100 || r_cyc !== 3) begin
            bad++; $display("FAIL sh_b2b got d=%h m=%b cyc=%0d exp beef0000,00001100,3", r_bdata[0], r_bmask[0], r_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_byte_store();
        test_half_loads();
        test_split();
        test_errors();
        test_dword_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
